// File: rtl/host_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : host_cmd_sequencer_pkg
// Brief   : Shared state, opcode and register-field definitions for the
//           host command sequencer.
// Revision: 1.0
// ============================================================================
package host_cmd_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_MUL  = 3'd2,
        ST_POST = 3'd3
    } state_e;

    localparam logic [3:0] c_op_nop      = 4'd0;
    localparam logic [3:0] c_op_add      = 4'd1;
    localparam logic [3:0] c_op_sub      = 4'd2;
    localparam logic [3:0] c_op_acc      = 4'd3;
    localparam logic [3:0] c_op_mul      = 4'd4;
    localparam logic [3:0] c_op_led_set  = 4'd5;
    localparam logic [3:0] c_op_led_blnk = 4'd6;
    localparam logic [3:0] c_op_clr      = 4'd7;

    localparam int c_cmd_op_lsb    = 0;
    localparam int c_cmd_abort_bit = 7;
    localparam int c_cmd_tag_lsb   = 8;

    localparam int c_st_busy_bit    = 7;
    localparam int c_st_err_bit     = 6;
    localparam int c_st_ovf_bit     = 5;
    localparam int c_st_overrun_bit = 4;
    localparam int c_st_aborted_bit = 3;

    function automatic logic [15:0] pack_status(
        input logic [7:0] done_tag,
        input logic       busy,
        input logic       err,
        input logic       ovf,
        input logic       overrun,
        input logic       aborted,
        input logic [2:0] state
    );
        logic [15:0] s;
        s                   = '0;
        s[15:8]             = done_tag;
        s[c_st_busy_bit]    = busy;
        s[c_st_err_bit]     = err;
        s[c_st_ovf_bit]     = ovf;
        s[c_st_overrun_bit] = overrun;
        s[c_st_aborted_bit] = aborted;
        s[2:0]              = state;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/host_cmd_sequencer_mul16.sv
`default_nettype none
// ============================================================================
// Module  : host_cmd_sequencer_mul16
// Brief   : 16-iteration shift-add multiplier, 32-bit product, abortable.
// Revision: 1.0
// ============================================================================
module host_cmd_sequencer_mul16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic        o_done,
    output logic [31:0] o_product
);
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] prod_q, prod_d;
    logic [15:0] mplier_q, mplier_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        active_q, active_d;

    always_comb begin
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (i_abort) begin
            active_d = 1'b0;
            prod_d   = '0;
        end else if (i_start) begin
            mcand_d  = {16'h0000, i_a};
            mplier_d = i_b;
            prod_d   = '0;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = {mcand_q[30:0], 1'b0};
            mplier_d = {1'b0, mplier_q[15:1]};
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    // High during the final iteration; the product is complete after this edge.
    assign o_done    = active_q & (&cnt_q);
    assign o_product = prod_q;

endmodule
`default_nettype wire

// File: rtl/host_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : host_cmd_sequencer
// Brief   : Tag-triggered host command executor with shared 16-bit ALU,
//           result/status posting and LED pattern/blink driver.
// Revision: 1.0
// ============================================================================
module host_cmd_sequencer
    import host_cmd_sequencer_pkg::*;
#(
    parameter int TAG_W      = 8,
    parameter int BLINK_LOG2 = 22
) (
    input  logic        ti_clk,
    input  logic        rst_n,
    input  logic [15:0] cmd_word,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    output logic [15:0] result,
    output logic [15:0] status,
    output logic [7:0]  led_on
);
    localparam logic [BLINK_LOG2-1:0] c_blink_one = {{(BLINK_LOG2-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [15:0]           a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0]      tag_q, tag_d, done_tag_q, done_tag_d, tag_prev_q, tag_prev_d;
    logic                  busy_q, busy_d, err_q, err_d, ovf_q, ovf_d;
    logic                  overrun_q, overrun_d, aborted_q, aborted_d, chg_seen_q, chg_seen_d;
    logic [15:0]           res_q, res_d, acc_q, acc_d, result_q, result_d, status_q, status_d;
    logic                  res_ovf_q, res_ovf_d, res_err_q, res_err_d;
    logic [7:0]            pattern_q, pattern_d, led_q, led_d;
    logic                  blink_q, blink_d, phase_q, phase_d;
    logic [BLINK_LOG2-1:0] blink_cnt_q, blink_cnt_d;

    logic [TAG_W-1:0] w_tag;
    logic             w_abort, w_tag_moved, w_mul_start, w_mul_abort, w_mul_done;
    logic [31:0]      w_mul_prod;
    logic [16:0]      w_add, w_sub, w_acc_add;
    logic             w_unused_rsvd;

    assign w_tag         = cmd_word[c_cmd_tag_lsb +: TAG_W];
    assign w_abort       = cmd_word[c_cmd_abort_bit];
    assign w_unused_rsvd = ^cmd_word[6:4];
    assign w_tag_moved   = (state_q != ST_IDLE) && (w_tag != tag_prev_q);
    assign w_mul_abort   = (state_q == ST_MUL) && w_abort;
    assign w_add         = {1'b0, a_q} + {1'b0, b_q};
    assign w_sub         = {1'b0, a_q} - {1'b0, b_q};
    assign w_acc_add     = {1'b0, acc_q} + {1'b0, a_q};

    host_cmd_sequencer_mul16 u_mul (
        .clk      (ti_clk),
        .rst_n    (rst_n),
        .i_start  (w_mul_start),
        .i_abort  (w_mul_abort),
        .i_a      (opa),
        .i_b      (opb),
        .o_done   (w_mul_done),
        .o_product(w_mul_prod)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        tag_d       = tag_q;
        done_tag_d  = done_tag_q;
        tag_prev_d  = w_tag;
        busy_d      = busy_q;
        err_d       = err_q;
        ovf_d       = ovf_q;
        overrun_d   = overrun_q;
        aborted_d   = aborted_q;
        chg_seen_d  = chg_seen_q;
        res_d       = res_q;
        res_ovf_d   = res_ovf_q;
        res_err_d   = res_err_q;
        acc_d       = acc_q;
        result_d    = result_q;
        pattern_d   = pattern_q;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q + c_blink_one;
        phase_d     = (&blink_cnt_q) ? ~phase_q : phase_q;
        w_mul_start = 1'b0;

        // A second tag change during one busy period means the host lost a command.
        if (w_tag_moved) begin
            chg_seen_d = 1'b1;
            if (chg_seen_q) begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (w_tag != done_tag_q) begin
                    op_d       = cmd_word[c_cmd_op_lsb +: 4];
                    a_d        = opa;
                    b_d        = opb;
                    tag_d      = w_tag;
                    busy_d     = 1'b1;
                    chg_seen_d = 1'b0;
                    if (cmd_word[c_cmd_op_lsb +: 4] == c_op_mul) begin
                        w_mul_start = 1'b1;
                        state_d     = ST_MUL;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (w_abort) begin
                    done_tag_d = tag_q;
                    aborted_d  = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    res_ovf_d = 1'b0;
                    res_err_d = 1'b0;
                    case (op_q)
                        c_op_add: begin
                            res_d     = w_add[15:0];
                            res_ovf_d = w_add[16];
                        end
                        c_op_sub: begin
                            res_d     = w_sub[15:0];
                            res_ovf_d = w_sub[16];
                        end
                        c_op_acc: begin
                            res_d     = w_acc_add[15:0];
                            res_ovf_d = w_acc_add[16];
                        end
                        c_op_clr: res_d = '0;
                        c_op_nop, c_op_mul, c_op_led_set, c_op_led_blnk: res_d = result_q;
                        default: begin
                            res_d     = result_q;
                            res_err_d = 1'b1;
                        end
                    endcase
                    state_d = ST_POST;
                end
            end
            ST_MUL: begin
                if (w_abort) begin
                    done_tag_d = tag_q;
                    aborted_d  = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else if (w_mul_done) begin
                    state_d = ST_POST;
                end
            end
            ST_POST: begin
                if (op_q == c_op_mul) begin
                    result_d = w_mul_prod[15:0];
                    ovf_d    = |w_mul_prod[31:16];
                    err_d    = 1'b0;
                end else begin
                    result_d = res_q;
                    ovf_d    = res_ovf_q;
                    err_d    = res_err_q;
                end
                case (op_q)
                    c_op_acc: acc_d = res_q;
                    c_op_clr: begin
                        acc_d     = '0;
                        overrun_d = 1'b0;
                        aborted_d = 1'b0;
                    end
                    c_op_led_set: begin
                        pattern_d = a_q[7:0];
                        blink_d   = 1'b0;
                    end
                    c_op_led_blnk: begin
                        pattern_d   = a_q[7:0];
                        blink_d     = 1'b1;
                        blink_cnt_d = '0;
                        phase_d     = 1'b1;
                    end
                    default: ;
                endcase
                done_tag_d = tag_q;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        led_d = (!blink_d || phase_d) ? pattern_d : 8'h00;
        // The state field reports the state that produced this status update.
        status_d = pack_status(done_tag_d, busy_d, err_d, ovf_d, overrun_d, aborted_d, state_q);
    end

    always_ff @(posedge ti_clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            done_tag_q  <= '0;
            tag_prev_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            overrun_q   <= 1'b0;
            aborted_q   <= 1'b0;
            chg_seen_q  <= 1'b0;
            res_q       <= '0;
            res_ovf_q   <= 1'b0;
            res_err_q   <= 1'b0;
            acc_q       <= '0;
            result_q    <= '0;
            status_q    <= '0;
            pattern_q   <= '0;
            led_q       <= '0;
            blink_q     <= 1'b0;
            phase_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            tag_q       <= tag_d;
            done_tag_q  <= done_tag_d;
            tag_prev_q  <= tag_prev_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            overrun_q   <= overrun_d;
            aborted_q   <= aborted_d;
            chg_seen_q  <= chg_seen_d;
            res_q       <= res_d;
            res_ovf_q   <= res_ovf_d;
            res_err_q   <= res_err_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            status_q    <= status_d;
            pattern_q   <= pattern_d;
            led_q       <= led_d;
            blink_q     <= blink_d;
            phase_q     <= phase_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign result = result_q;
    assign status = status_q;
    assign led_on = led_q;

endmodule
`default_nettype wire

// File: tb/tb_host_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_host_cmd_sequencer
// Brief   : Directed plus randomized bench for host_cmd_sequencer against a
//           cycle-counted behavioural model of the command protocol.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_host_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cmd_word, opa, opb;
    logic [15:0] result, status;
    logic [7:0]  led_on;

    always #5 clk = ~clk;

    host_cmd_sequencer #(.TAG_W(8), .BLINK_LOG2(3)) dut (
        .ti_clk  (clk),
        .rst_n   (rst_n),
        .cmd_word(cmd_word),
        .opa     (opa),
        .opb     (opb),
        .result  (result),
        .status  (status),
        .led_on  (led_on)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_result, m_acc;
    logic [7:0]  m_done_tag, m_led;
    logic        m_err, m_ovf, m_ovr, m_abt, m_blink;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk_status(input logic [7:0] t, input logic busy, input logic err,
                                              input logic ovf, input logic ovr, input logic abt,
                                              input logic [2:0] st);
        return {t, busy, err, ovf, ovr, abt, st};
    endfunction

    task automatic model_reset();
        m_result = '0; m_acc = '0; m_done_tag = '0; m_led = '0;
        m_err = 0; m_ovf = 0; m_ovr = 0; m_abt = 0; m_blink = 0;
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); @(negedge clk);
            chk("idle_status", status, mk_status(m_done_tag, 0, m_err, m_ovf, m_ovr, m_abt, 3'd0));
            chk("idle_result", result, m_result);
            if (!m_blink) chk("idle_led", led_on, m_led);
        end
    endtask

    // Issues one command (or follows a pending one when reuse=1) and checks
    // every cycle until it posts or is aborted.
    task automatic exec_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            input int abort_at, input int n_chg, input bit reuse);
        logic [7:0]  tag;
        logic [2:0]  run_st;
        int          lat;
        bit          was_aborted;
        int unsigned wide;
        lat         = (op == 4'd4) ? 17 : 2;
        run_st      = (op == 4'd4) ? 3'd2 : 3'd1;
        was_aborted = 0;
        if (reuse) begin
            tag = cmd_word[15:8];
        end else begin
            tag      = m_done_tag + 8'd1;
            cmd_word = {tag, 1'b0, 3'($urandom_range(0, 7)), op};
            opa      = a;
            opb      = b;
        end
        @(posedge clk); @(negedge clk);
        chk("accept_status", status, mk_status(m_done_tag, 1, m_err, m_ovf, m_ovr, m_abt, 3'd0));
        for (int k = 1; k <= lat; k++) begin
            if (k == abort_at) cmd_word[7] = 1'b1;
            if (n_chg >= 1 && k == 2) cmd_word[15:8] = tag + 8'd1;
            if (n_chg >= 2 && k == 4) begin
                cmd_word[15:8] = tag + 8'd2;
                m_ovr = 1'b1;
            end
            @(posedge clk); @(negedge clk);
            if (k == abort_at) begin
                cmd_word[7] = 1'b0;
                m_done_tag  = tag;
                m_abt       = 1'b1;
                chk("abort_status", status, mk_status(tag, 0, m_err, m_ovf, m_ovr, 1, run_st));
                chk("abort_result", result, m_result);
                was_aborted = 1;
                break;
            end
            if (k < lat) begin
                chk("busy_status", status, mk_status(m_done_tag, 1, m_err, m_ovf, m_ovr, m_abt, run_st));
                chk("busy_result", result, m_result);
            end
        end
        if (!was_aborted) begin
            m_err = 0;
            m_ovf = 0;
            case (op)
                4'd0: ;
                4'd1: begin
                    wide = 32'(a) + 32'(b);
                    m_result = wide[15:0];
                    m_ovf = (wide > 32'h0000_FFFF);
                end
                4'd2: begin
                    m_result = a - b;
                    m_ovf = (a < b);
                end
                4'd3: begin
                    wide = 32'(m_acc) + 32'(a);
                    m_acc = wide[15:0];
                    m_result = m_acc;
                    m_ovf = (wide > 32'h0000_FFFF);
                end
                4'd4: begin
                    wide = 32'(a) * 32'(b);
                    m_result = wide[15:0];
                    m_ovf = (wide[31:16] != 16'h0000);
                end
                4'd5: begin
                    m_led = a[7:0];
                    m_blink = 0;
                end
                4'd6: m_blink = 1;
                4'd7: begin
                    m_acc = '0; m_result = '0; m_ovr = 0; m_abt = 0;
                end
                default: m_err = 1;
            endcase
            m_done_tag = tag;
            chk("post_status", status, mk_status(tag, 0, m_err, m_ovf, m_ovr, m_abt, 3'd3));
            chk("post_result", result, m_result);
            if (!m_blink) chk("post_led", led_on, m_led);
        end
    endtask

    task automatic check_blink(input logic [7:0] pat, input int n);
        for (int t = 0; t < n; t++) begin
            chk("blink_led", led_on, (((t / 8) % 2) == 0) ? pat : 8'h00);
            @(posedge clk); @(negedge clk);
        end
    endtask

    logic [3:0]  r_op;
    logic [15:0] r_a, r_b;
    int          r_ab;

    initial begin
        rst_n = 0; cmd_word = '0; opa = '0; opb = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_result", result, 16'h0000);
        chk("reset_status", status, 16'h0000);
        chk("reset_led", led_on, 8'h00);
        rst_n = 1;
        idle_check(2);

        exec_cmd(4'd1, 16'h1234, 16'h0FFF, 0, 0, 0);
        chk("t1_result", result, 16'h2233);
        chk("t1_status", status, 16'h0103);
        idle_check(1);
        chk("t1_idle_status", status, 16'h0100);

        exec_cmd(4'd1, 16'hFFFF, 16'h0002, 0, 0, 0);
        chk("t2_add_wrap", result, 16'h0001);
        exec_cmd(4'd2, 16'h0001, 16'h0002, 0, 0, 0);
        chk("t2_sub_wrap", result, 16'hFFFF);

        exec_cmd(4'd4, 16'h0100, 16'h0100, 0, 0, 0);
        chk("t3_mul_ovf", status[5], 1'b1);
        exec_cmd(4'd4, 16'h00FF, 16'h0101, 0, 0, 0);
        chk("t3_mul_ffff", result, 16'hFFFF);

        exec_cmd(4'd4, 16'h0003, 16'h0005, 0, 2, 0);
        exec_cmd(4'd4, 16'h0003, 16'h0005, 0, 0, 1);
        chk("t4_overrun", status[4], 1'b1);
        exec_cmd(4'd7, 16'h0000, 16'h0000, 0, 0, 0);
        chk("t4_clr_overrun", status[4], 1'b0);
        exec_cmd(4'd3, 16'h1111, 16'h0000, 0, 0, 0);
        chk("t4_acc_after_clr", result, 16'h1111);

        exec_cmd(4'd4, 16'h1234, 16'h5678, 5, 0, 0);
        chk("t5_aborted", status[3], 1'b1);
        idle_check(1);
        exec_cmd(4'hC, 16'h7777, 16'h8888, 0, 0, 0);
        chk("t5_err", status[6], 1'b1);

        exec_cmd(4'd6, 16'h00A5, 16'h0000, 0, 0, 0);
        check_blink(8'hA5, 24);
        exec_cmd(4'd5, 16'h000F, 16'h0000, 0, 0, 0);
        idle_check(10);

        for (int i = 0; i < 40; i++) begin
            r_op = 4'($urandom_range(0, 15));
            if (r_op == 4'd6) r_op = 4'd5;
            r_a = 16'($urandom);
            r_b = 16'($urandom);
            if ($urandom_range(0, 3) == 0) r_a = 16'hFFFF;
            r_ab = 0;
            if ($urandom_range(0, 5) == 0) r_ab = $urandom_range(1, (r_op == 4'd4) ? 16 : 1);
            exec_cmd(r_op, r_a, r_b, r_ab, 0, 0);
            if ($urandom_range(0, 1) == 1) idle_check(1);
        end

        cmd_word = {m_done_tag + 8'd1, 4'h0, 4'd4};
        opa = 16'h0ABC; opb = 16'h0123;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_mid_busy", status[7], 1'b1);
        rst_n = 0; cmd_word = '0;
        @(posedge clk); @(negedge clk);
        chk("rst_mid_result", result, 16'h0000);
        chk("rst_mid_status", status, 16'h0000);
        chk("rst_mid_led", led_on, 8'h00);
        rst_n = 1;
        model_reset();
        idle_check(2);
        exec_cmd(4'd1, 16'h0010, 16'h0020, 0, 0, 0);
        chk("after_rst_add", result, 16'h0030);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
